// File: rtl/if_id_latch.sv
// IF/ID pipeline register: captures fetch word and PC+2, supports stall/flush, and
// freezes fetch on HALT. Optional perf counters behind `IFID_PERF_CNT_EN`.
module if_id_latch #(
    parameter logic [15:0] NOP_WORD = 16'h0800,
    parameter logic [4:0]  HALT_OPC = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        fetch_hold,
    output logic        halt_out
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0] instr_cnt,
    output logic [15:0] bubble_cnt
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        ld_instr;
    logic        ld_bubble;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        ld_instr  = 1'b0;
        ld_bubble = 1'b0;
        if (flush) begin
            // A flush also cancels a wrong-path HALT, releasing fetch.
            instr_d   = NOP_WORD;
            pc_d      = pc_plus2_in;
            valid_d   = 1'b0;
            state_d   = RUN;
            ld_bubble = 1'b1;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    instr_d  = instr_in;
                    pc_d     = pc_plus2_in;
                    valid_d  = 1'b1;
                    ld_instr = 1'b1;
                    if (instr_in[15:11] == HALT_OPC) state_d = HALTED;
                end
                HALTED: begin
                    // HALT has moved on; fetch is frozen so only bubbles follow.
                    instr_d   = NOP_WORD;
                    pc_d      = pc_plus2_in;
                    valid_d   = 1'b0;
                    ld_bubble = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            instr_q <= NOP_WORD;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_plus2_out = pc_q;
    assign valid_out    = valid_q;
    assign fetch_hold   = (state_q == HALTED);
    assign halt_out     = valid_q && (instr_q[15:11] == HALT_OPC);

`ifdef IFID_PERF_CNT_EN
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] bcnt_q, bcnt_d;

    always_comb begin
        icnt_d = icnt_q;
        bcnt_d = bcnt_q;
        if (ld_instr && icnt_q != 16'hFFFF) icnt_d = icnt_q + 16'd1;
        if (ld_bubble && bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_q <= 16'h0000;
            bcnt_q <= 16'h0000;
        end else begin
            icnt_q <= icnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign instr_cnt  = icnt_q;
    assign bubble_cnt = bcnt_q;
`else
    logic unused_ld;
    assign unused_ld = ld_instr ^ ld_bubble;
`endif

endmodule
